// File: rtl/watchdog_kicker.sv
// -----------------------------------------------------------------------------
// watchdog_kicker
//
// Heartbeat generator for a board-level watchdog. Alive strobes from each
// monitored channel are collected over a fixed period. At the end of the
// period a kick pulse is issued only if every channel strobed. When enough
// consecutive periods are missed, a sticky fault is latched and kicking stops,
// so the downstream watchdog expires.
//
// Handshake/level semantics: ipEnable is a plain level (high = run). ipAlive
// bits are single-cycle strobes sampled on every rising ipClk edge. There is
// no valid/ready flow control; every output is a registered level or pulse.
//
// Ports
//   ipClk       in   1         clock, single domain
//   ipReset     in   1         asynchronous, active-high reset
//   ipEnable    in   1         high = run, low = idle (ignored in FAULT)
//   ipAlive     in   Channels  per-channel alive strobes
//   opKick      out  1         kick pulse, Pulse_cycles wide
//   opMissed    out  1         one-cycle pulse per missed period
//   opMissMask  out  Channels  channels not seen in the last evaluated period
//   opFault     out  1         sticky fault, cleared only by ipReset
//   opState     out  2         debug view of the FSM: 0 IDLE, 1 RUN, 2 FAULT
// -----------------------------------------------------------------------------
module watchdog_kicker #(
    parameter int Clk_Frequency = 50_000_000,
    parameter int Period_ms     = 100,
    parameter int Pulse_cycles  = 4,
    parameter int Channels      = 4,
    parameter int Max_Misses    = 3
) (
    input  logic                ipClk,
    input  logic                ipReset,
    input  logic                ipEnable,
    input  logic [Channels-1:0] ipAlive,
    output logic                opKick,
    output logic                opMissed,
    output logic [Channels-1:0] opMissMask,
    output logic                opFault,
    output logic [1:0]          opState
);

    // Product done in 64 bits: 50 MHz * 100 ms overflows a 32-bit int.
    localparam longint PERIOD_L      = (longint'(Clk_Frequency) * longint'(Period_ms)) / 64'sd1000;
    localparam int     Period_cycles = int'(PERIOD_L);
    localparam int     CW            = (Period_cycles > 1) ? $clog2(Period_cycles) : 1;
    localparam int     PW            = $clog2(Pulse_cycles + 1);
    localparam int     MW            = $clog2(Max_Misses + 1);

    localparam logic [CW-1:0] COUNT_LOAD = CW'(Period_cycles - 1);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(Pulse_cycles);
    localparam logic [MW-1:0] MISS_LIMIT = MW'(Max_Misses);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       count_q;
    logic [PW-1:0]       pulse_q;
    logic [MW-1:0]       misses_q;
    logic [Channels-1:0] seen_q;
    logic [Channels-1:0] mask_q;
    logic                kick_q;
    logic                missed_q;
    logic                fault_q;

    // A strobe arriving on the evaluation cycle still belongs to the
    // closing period, so evaluation looks at seen_q merged with ipAlive.
    logic [Channels-1:0] all_d;
    logic [MW-1:0]       misses_d;

    assign all_d    = seen_q | ipAlive;
    assign misses_d = misses_q + MW'(1);

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            pulse_q  <= '0;
            misses_q <= '0;
            seen_q   <= '0;
            mask_q   <= '0;
            kick_q   <= 1'b0;
            missed_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            missed_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    kick_q  <= 1'b0;
                    pulse_q <= '0;
                    if (ipEnable) begin
                        state_q  <= RUN;
                        count_q  <= COUNT_LOAD;
                        seen_q   <= '0;
                        misses_q <= '0;
                    end
                end

                RUN: begin
                    if (!ipEnable) begin
                        // Abort everything except the last reported mask.
                        state_q  <= IDLE;
                        kick_q   <= 1'b0;
                        pulse_q  <= '0;
                        count_q  <= '0;
                        seen_q   <= '0;
                        misses_q <= '0;
                    end else begin
                        // Pulse timer: pulse_q holds the high cycles still
                        // owed including the current one, so the kick drops
                        // when the last one is being spent.
                        if (pulse_q != '0) begin
                            pulse_q <= pulse_q - PW'(1);
                            kick_q  <= (pulse_q != PW'(1));
                        end

                        if (count_q != '0) begin
                            count_q <= count_q - CW'(1);
                            seen_q  <= all_d;
                        end else begin
                            count_q <= COUNT_LOAD;
                            seen_q  <= '0;
                            if (&all_d) begin
                                kick_q   <= 1'b1;
                                pulse_q  <= PULSE_LOAD;
                                misses_q <= '0;
                                mask_q   <= '0;
                            end else begin
                                missed_q <= 1'b1;
                                mask_q   <= ~all_d;
                                misses_q <= misses_d;
                                if (misses_d == MISS_LIMIT) begin
                                    state_q <= FAULT;
                                    fault_q <= 1'b1;
                                    kick_q  <= 1'b0;
                                    pulse_q <= '0;
                                end
                            end
                        end
                    end
                end

                FAULT: begin
                    // Terminal until reset: never kick again.
                    kick_q  <= 1'b0;
                    pulse_q <= '0;
                    fault_q <= 1'b1;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign opKick     = kick_q;
    assign opMissed   = missed_q;
    assign opMissMask = mask_q;
    assign opFault    = fault_q;
    assign opState    = state_q;

endmodule

// File: tb/tb_watchdog_kicker.sv
// -----------------------------------------------------------------------------
// tb_watchdog_kicker
//
// Directed bench for watchdog_kicker with Period_cycles = 10, Pulse_cycles = 2,
// Channels = 2, Max_Misses = 2. A behavioural model tracks time since enable,
// and derives the outputs from period arithmetic; one process compares it to
// the DUT every cycle, and the directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_watchdog_kicker;

    localparam int P     = 10;
    localparam int PULSE = 2;
    localparam int MAXM  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FAULT = 2;

    // ---------------- clock / reset ----------------
    logic       ipClk    = 1'b0;
    logic       ipReset  = 1'b1;
    logic       ipEnable = 1'b0;
    logic [1:0] ipAlive  = 2'b00;

    logic       opKick;
    logic       opMissed;
    logic [1:0] opMissMask;
    logic       opFault;
    logic [1:0] opState;

    always #5 ipClk = ~ipClk;

    watchdog_kicker #(
        .Clk_Frequency (1000),
        .Period_ms     (10),
        .Pulse_cycles  (PULSE),
        .Channels      (2),
        .Max_Misses    (MAXM)
    ) dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipEnable   (ipEnable),
        .ipAlive    (ipAlive),
        .opKick     (opKick),
        .opMissed   (opMissed),
        .opMissMask (opMissMask),
        .opFault    (opFault),
        .opState    (opState)
    );

    // ---------------- scoreboard counters ----------------
    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k counts edges since the enabling edge; period boundaries are the
    // multiples of P. A kick is owed for PULSE cycles after a good boundary.
    int         m_mode    = M_IDLE;
    int         m_k       = 0;
    int         m_misses  = 0;
    int         m_kick_at = -1000;
    logic [1:0] m_seen    = 2'b00;
    logic [1:0] m_mask    = 2'b00;
    logic       m_missed  = 1'b0;
    logic [1:0] m_all;

    always @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            m_mode    = M_IDLE;
            m_k       = 0;
            m_misses  = 0;
            m_kick_at = -1000;
            m_seen    = 2'b00;
            m_mask    = 2'b00;
            m_missed  = 1'b0;
        end else begin
            m_missed = 1'b0;
            if (m_mode == M_IDLE) begin
                if (ipEnable) begin
                    m_mode    = M_RUN;
                    m_k       = 0;
                    m_seen    = 2'b00;
                    m_misses  = 0;
                    m_kick_at = -1000;
                end
            end else if (m_mode == M_RUN) begin
                if (!ipEnable) begin
                    m_mode    = M_IDLE;
                    m_kick_at = -1000;
                end else begin
                    m_k++;
                    m_all = m_seen | ipAlive;
                    if (m_k % P == 0) begin
                        m_seen = 2'b00;
                        if (m_all == 2'b11) begin
                            m_kick_at = m_k;
                            m_mask    = 2'b00;
                            m_misses  = 0;
                        end else begin
                            m_missed = 1'b1;
                            m_mask   = ~m_all;
                            m_misses++;
                            if (m_misses == MAXM) begin
                                m_mode    = M_FAULT;
                                m_kick_at = -1000;
                            end
                        end
                    end else begin
                        m_seen = m_all;
                    end
                end
            end
        end
    end

    function automatic logic exp_kick();
        return (m_mode == M_RUN) && ((m_k - m_kick_at) < PULSE);
    endfunction

    // Per-cycle compare, away from the active edge.
    always @(negedge ipClk) begin
        if (cmp_on) begin
            chk("cyc_kick",   32'(opKick),     32'(exp_kick()));
            chk("cyc_missed", 32'(opMissed),   32'(m_missed));
            chk("cyc_mask",   32'(opMissMask), 32'(m_mask));
            chk("cyc_fault",  32'(opFault),    32'(m_mode == M_FAULT));
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs are applied 2 ns after an edge and sampled by the next edge;
    // on return the outputs reflect that edge.
    task automatic cyc(input logic en, input logic [1:0] al);
        ipEnable = en;
        ipAlive  = al;
        @(posedge ipClk);
        #2;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any edge.
    task automatic do_reset(input string tag);
        ipEnable = 1'b0;
        ipAlive  = 2'b00;
        #1 ipReset = 1'b1;
        #1;
        chk({tag, "_kick"},   32'(opKick),     32'd0);
        chk({tag, "_missed"}, 32'(opMissed),   32'd0);
        chk({tag, "_mask"},   32'(opMissMask), 32'd0);
        chk({tag, "_fault"},  32'(opFault),    32'd0);
        chk({tag, "_state"},  32'(opState),    32'd0);
        @(posedge ipClk);
        #2 ipReset = 1'b0;
    endtask

    // ---------------- directed sequences ----------------
    initial begin
        repeat (2) @(posedge ipClk);
        #2;
        chk("rst_kick",   32'(opKick),     32'd0);
        chk("rst_missed", 32'(opMissed),   32'd0);
        chk("rst_mask",   32'(opMissMask), 32'd0);
        chk("rst_fault",  32'(opFault),    32'd0);
        chk("rst_state",  32'(opState),    32'd0);
        ipReset = 1'b0;
        cmp_on  = 1'b1;

        // S1: full strobes every 3 cycles, kicks after e10/e20/e30.
        cyc(1'b1, 2'b00);
        for (int j = 1; j <= 30; j++) begin
            cyc(1'b1, (j % 3 == 0) ? 2'b11 : 2'b00);
            if (j == 9)                        chk("s1_kick_pre", 32'(opKick), 32'd0);
            if (j == 10 || j == 20 || j == 30) chk("s1_kick_on",  32'(opKick), 32'd1);
            if (j == 10 || j == 20 || j == 30) chk("s1_missed",   32'(opMissed), 32'd0);
            if (j == 11 || j == 21)            chk("s1_kick_2nd", 32'(opKick), 32'd1);
            if (j == 12 || j == 22)            chk("s1_kick_off", 32'(opKick), 32'd0);
        end
        cyc(1'b0, 2'b00);
        chk("s1_dis_kick",  32'(opKick),  32'd0);
        chk("s1_dis_state", 32'(opState), 32'd0);

        // S2: partial period then full period.
        do_reset("s2r");
        cyc(1'b1, 2'b00);
        for (int j = 1; j <= 22; j++) begin
            cyc(1'b1, (j == 4) ? 2'b01 : ((j == 15) ? 2'b11 : 2'b00));
            if (j == 10) begin
                chk("s2_kick_miss", 32'(opKick),     32'd0);
                chk("s2_missed",    32'(opMissed),   32'd1);
                chk("s2_mask",      32'(opMissMask), 32'd2);
            end
            if (j == 11) begin
                chk("s2_missed_end", 32'(opMissed),   32'd0);
                chk("s2_mask_hold",  32'(opMissMask), 32'd2);
            end
            if (j == 20) begin
                chk("s2_kick_good", 32'(opKick),     32'd1);
                chk("s2_mask_clr",  32'(opMissMask), 32'd0);
                chk("s2_no_missed", 32'(opMissed),   32'd0);
            end
            if (j == 22) chk("s2_kick_off", 32'(opKick), 32'd0);
        end

        // S3: two empty periods latch the fault; later activity is ignored.
        do_reset("s3r");
        cyc(1'b1, 2'b00);
        for (int j = 1; j <= 20; j++) begin
            cyc(1'b1, 2'b00);
            if (j == 10) begin
                chk("s3_missed1", 32'(opMissed),   32'd1);
                chk("s3_mask1",   32'(opMissMask), 32'd3);
                chk("s3_nofault", 32'(opFault),    32'd0);
            end
            if (j == 20) begin
                chk("s3_missed2", 32'(opMissed), 32'd1);
                chk("s3_fault",   32'(opFault),  32'd1);
                chk("s3_kick",    32'(opKick),   32'd0);
                chk("s3_state",   32'(opState),  32'd2);
            end
        end
        for (int j = 21; j <= 40; j++) begin
            cyc((j % 4) != 0, (j % 2 == 1) ? 2'b11 : 2'b00);
        end
        chk("s3_late_kick",  32'(opKick),  32'd0);
        chk("s3_late_fault", 32'(opFault), 32'd1);

        // Reset out of FAULT.
        do_reset("s3f");

        // S4: channel 1 only on the evaluation cycle still counts.
        cyc(1'b1, 2'b00);
        for (int j = 1; j <= 20; j++) begin
            cyc(1'b1, (j == 2) ? 2'b01 : ((j == 10) ? 2'b10 : ((j == 12) ? 2'b01 : 2'b00)));
            if (j == 10) begin
                chk("s4_kick",   32'(opKick),   32'd1);
                chk("s4_missed", 32'(opMissed), 32'd0);
            end
            if (j == 20) begin
                chk("s4_p2_kick",   32'(opKick),     32'd0);
                chk("s4_p2_missed", 32'(opMissed),   32'd1);
                chk("s4_p2_mask",   32'(opMissMask), 32'd2);
            end
        end

        // S5: drop enable during the kick, then re-enable.
        do_reset("s5r");
        cyc(1'b1, 2'b00);
        for (int j = 1; j <= 11; j++) begin
            cyc(j != 11, (j == 5) ? 2'b11 : 2'b00);
            if (j == 10) chk("s5_kick", 32'(opKick), 32'd1);
            if (j == 11) begin
                chk("s5_abort_kick",  32'(opKick),  32'd0);
                chk("s5_abort_state", 32'(opState), 32'd0);
            end
        end
        cyc(1'b0, 2'b00);
        cyc(1'b1, 2'b00);
        for (int r = 1; r <= 20; r++) begin
            cyc(1'b1, (r == 5) ? 2'b11 : 2'b00);
            if (r == 9)  chk("s5_re_early", 32'(opKick), 32'd0);
            if (r == 10) chk("s5_re_kick",  32'(opKick), 32'd1);
            if (r == 20) begin
                chk("s5_re_missed", 32'(opMissed), 32'd1);
                chk("s5_re_fault",  32'(opFault),  32'd0);
            end
        end
        // One miss is pending; disable must forget it.
        cyc(1'b0, 2'b00);
        cyc(1'b1, 2'b00);
        for (int r = 1; r <= 10; r++) begin
            cyc(1'b1, 2'b00);
            if (r == 10) begin
                chk("s5_clr_missed", 32'(opMissed), 32'd1);
                chk("s5_clr_fault",  32'(opFault),  32'd0);
                chk("s5_clr_state",  32'(opState),  32'd1);
            end
        end

        // S6: async reset mid-period and mid-pulse.
        do_reset("s6a");
        cyc(1'b1, 2'b00);
        for (int j = 1; j <= 6; j++) cyc(1'b1, (j == 3) ? 2'b11 : 2'b00);
        chk("s6_run_state", 32'(opState), 32'd1);
        do_reset("s6mid");
        cyc(1'b1, 2'b00);
        for (int j = 1; j <= 10; j++) cyc(1'b1, (j == 5) ? 2'b11 : 2'b00);
        chk("s6_pulse_kick", 32'(opKick), 32'd1);
        do_reset("s6pulse");
        repeat (3) cyc(1'b0, 2'b00);

        cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound on the whole run in case the sequence ever stalls.
    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: run exceeded 200000 ns");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/watchdog_kicker.md
# watchdog_kicker

Heartbeat generator that drives a watchdog's kick input. It collects per-subsystem "alive" strobes over a fixed period and emits a kick pulse at the end of each period only if every monitored channel strobed. Consecutive missed periods latch a fault and stop kicking permanently, so the downstream watchdog expires. It sits between the application subsystems and the board-level watchdog, in the clocking and reset library.

## Interface
- Clk_Frequency, 50_000_000: ipClk frequency in Hz.
- Period_ms, 100: kick period in ms. Period_cycles = Clk_Frequency * Period_ms / 1000; must be ≥ 2.
- Pulse_cycles, 4: opKick high time in cycles; 1 ≤ Pulse_cycles < Period_cycles.
- Channels, 4: number of monitored alive inputs.
- Max_Misses, 3: consecutive missed periods that latch the fault; must be ≥ 1.

Ports:
- ipClk  in  1  clock; single clock domain.
- ipReset  in  1  asynchronous, active-high reset.
- ipEnable  in  1  level; high = run, low = idle (ignored in FAULT).
- ipAlive  in  Channels  per-channel 1-cycle strobes, synchronous to ipClk.
- opKick  out  1  kick pulse, Pulse_cycles wide.
- opMissed  out  1  1-cycle pulse per missed period.
- opMissMask  out  Channels  registered mask of channels not seen in the last evaluated period.
- opFault  out  1  sticky fault; cleared only by ipReset.

## Operation
- Reset values: opKick = 0, opMissed = 0, opMissMask = 0, opFault = 0, state IDLE, Seen = 0, Misses = 0.
- States: IDLE, RUN, FAULT.
- IDLE:
  - Outputs low.
  - ipEnable = 1 → RUN, Count ← Period_cycles − 1, Seen ← 0, Misses ← 0.
- RUN, every cycle:
  - Seen ← Seen | ipAlive.
  - Count ≠ 0 → Count decrements.
  - Count = 0 → evaluate All = Seen | ipAlive (a strobe on the evaluation cycle counts for the closing period), then Count ← Period_cycles − 1 and Seen ← 0.
- Evaluation, All all-ones:
  - Start kick: PulseCount ← Pulse_cycles, opKick = 1 for Pulse_cycles cycles.
  - Misses ← 0, opMissMask ← 0.
- Evaluation, otherwise:
  - No kick; opMissed pulses; opMissMask ← ~All.
  - Misses increments; if the new value = Max_Misses → FAULT.
- A kick pulse may overlap the start of the next period. Alive strobes during the pulse count toward the new period.
- ipEnable falls in RUN → IDLE next cycle:
  - opKick forced 0, pulse aborted.
  - Seen, Misses, Count cleared; opMissMask holds its value.
- FAULT:
  - opFault = 1, opKick = 0, opMissed = 0; ipAlive and ipEnable ignored.
  - Only ipReset exits.
- Async reset mid-pulse or mid-period: all state and outputs return to reset values immediately.
- Widths:
  - Count: clog2(Period_cycles).
  - PulseCount: clog2(Pulse_cycles + 1).
  - Misses: clog2(Max_Misses + 1); saturation is not needed because FAULT stops counting.

## Timing
- All outputs are registered.
- Edge e0 samples ipEnable = 1 in IDLE; RUN starts after e0.
- First evaluation at edge e0 + Period_cycles; subsequent evaluations every Period_cycles edges, with no drift.
- opKick rises after the evaluation edge and stays high for exactly Pulse_cycles cycles.
- opMissed and opMissMask update after the evaluation edge, in the same cycle opKick would have risen.
- opFault rises after the evaluation edge of the Max_Misses-th consecutive miss, in the same cycle as that opMissed.
- ipEnable deassert sampled at edge e → opKick low after e.

## Test plan
Bench configuration: Clk_Frequency = 1000, Period_ms = 10 (Period_cycles = 10), Pulse_cycles = 2, Channels = 2, Max_Misses = 2.
- Reset, enable at e0, strobe ipAlive = 2'b11 every 3 cycles → opKick high for 2 cycles after e10, e20, e30; opMissed never pulses.
- Strobe only bit 0 in period 1 → no kick after e10, opMissed pulse, opMissMask = 2'b10. Full strobes in period 2 → kick after e20, opMissMask = 2'b00.
- Two consecutive empty periods → opMissed after e10 and e20; opFault = 1 after e20. Later strobes and enable toggles → opKick stays 0.
- Channel 1 strobes only at the evaluation cycle (e10), channel 0 earlier → kick issued after e10.
- Drop ipEnable during the kick pulse (cycle after e10) → opKick low next cycle. Re-enable → first kick Period_cycles later, Misses = 0.
- Assert ipReset asynchronously mid-period and while in FAULT → all outputs 0 immediately, state IDLE.
